// File: rtl/i2c_master_scheduler.sv
// rtl/i2c_master_scheduler.sv - round-robin arbiter and transaction sequencer for the I2C master driver
module i2c_master_scheduler #(
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 1024,
    parameter int GAP        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic                  req_rw0,
    input  logic                  req_rw1,
    input  logic [LEN_WIDTH-1:0]  req_len0,
    input  logic [LEN_WIDTH-1:0]  req_len1,
    output logic [1:0]            grant,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic                  busy,
    output logic                  drv_start,
    output logic [ADDR_WIDTH-1:0] drv_addr,
    output logic                  drv_rw,
    input  logic                  drv_byte,
    input  logic                  drv_nack,
    input  logic                  drv_stop
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_XFER      = 3'd2;
    localparam logic [2:0] S_WAIT_STOP = 3'd3;
    localparam logic [2:0] S_GAP_WAIT  = 3'd4;

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    logic [2:0]           state;
    logic                 last;
    logic                 owner;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 err_flag;
    logic [WD_W-1:0]      wd;
    logic [GAP_W-1:0]     gap_cnt;

    logic                 pick;
    logic [1:0]           owner_oh;
    logic                 count_full;
    logic                 timeout_hit;

    // Round-robin pick: with both pending, the requester that did not own the bus last wins.
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last;
        end
    end

    assign owner_oh    = owner ? 2'b10 : 2'b01;
    assign count_full  = drv_byte && (({1'b0, cnt} + {{LEN_WIDTH{1'b0}}, 1'b1}) == {1'b0, len_q});
    assign timeout_hit = (wd == WD_W'(TIMEOUT - 1));

    // Transaction sequencer: arbitration, driver kick-off, byte counting, watchdog and inter-transaction gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            len_q     <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            wd        <= '0;
            gap_cnt   <= '0;
            grant     <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            busy      <= 1'b0;
            drv_start <= 1'b0;
            drv_addr  <= '0;
            drv_rw    <= 1'b0;
        end else begin
            grant     <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            drv_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner    <= pick;
                        grant    <= pick ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        drv_addr <= pick ? req_addr1 : req_addr0;
                        drv_rw   <= pick ? req_rw1 : req_rw0;
                        len_q    <= pick ? req_len1 : req_len0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    cnt      <= '0;
                    err_flag <= 1'b0;
                    wd       <= '0;
                    if (len_q == '0) begin
                        // Nothing to move: report and skip the driver entirely.
                        err     <= owner_oh;
                        gap_cnt <= '0;
                        state   <= S_GAP_WAIT;
                    end else begin
                        drv_start <= 1'b1;
                        state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    wd <= wd + WD_W'(1);
                    if (drv_stop) begin
                        // STOP wins over every other event; only a completing byte makes it a success.
                        if (count_full && !drv_nack) begin
                            done <= owner_oh;
                        end else begin
                            err <= owner_oh;
                        end
                        gap_cnt <= '0;
                        state   <= S_GAP_WAIT;
                    end else if (drv_nack) begin
                        err_flag <= 1'b1;
                        if (drv_byte) begin
                            cnt <= cnt + LEN_WIDTH'(1);
                        end
                        wd    <= '0;
                        state <= S_WAIT_STOP;
                    end else if (drv_byte) begin
                        cnt <= cnt + LEN_WIDTH'(1);
                        wd  <= '0;
                        if (count_full) begin
                            state <= S_WAIT_STOP;
                        end
                    end else if (timeout_hit) begin
                        err     <= owner_oh;
                        gap_cnt <= '0;
                        state   <= S_GAP_WAIT;
                    end
                end
                S_WAIT_STOP: begin
                    wd <= wd + WD_W'(1);
                    if (drv_stop) begin
                        if (err_flag || drv_nack) begin
                            err <= owner_oh;
                        end else begin
                            done <= owner_oh;
                        end
                        gap_cnt <= '0;
                        state   <= S_GAP_WAIT;
                    end else begin
                        if (drv_nack) begin
                            err_flag <= 1'b1;
                        end
                        // Surplus bytes keep the watchdog alive but never advance the saturated count.
                        if (drv_byte) begin
                            wd <= '0;
                        end else if (timeout_hit) begin
                            err     <= owner_oh;
                            gap_cnt <= '0;
                            state   <= S_GAP_WAIT;
                        end
                    end
                end
                S_GAP_WAIT: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_scheduler.sv
// tb/tb_i2c_master_scheduler.sv - self-checking bench for i2c_master_scheduler
module tb_i2c_master_scheduler;

    localparam int AW = 7;
    localparam int LW = 4;
    localparam int TO = 16;
    localparam int GP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic          req_rw0 = 1'b0;
    logic          req_rw1 = 1'b0;
    logic [LW-1:0] req_len0 = '0;
    logic [LW-1:0] req_len1 = '0;
    logic [1:0]    grant;
    logic [1:0]    done;
    logic [1:0]    err;
    logic          busy;
    logic          drv_start;
    logic [AW-1:0] drv_addr;
    logic          drv_rw;
    logic          drv_byte = 1'b0;
    logic          drv_nack = 1'b0;
    logic          drv_stop = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int last_owner = 1;

    always #5 clk = ~clk;

    i2c_master_scheduler #(
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .TIMEOUT   (TO),
        .GAP       (GP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr0(req_addr0),
        .req_addr1(req_addr1),
        .req_rw0  (req_rw0),
        .req_rw1  (req_rw1),
        .req_len0 (req_len0),
        .req_len1 (req_len1),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .drv_start(drv_start),
        .drv_addr (drv_addr),
        .drv_rw   (drv_rw),
        .drv_byte (drv_byte),
        .drv_nack (drv_nack),
        .drv_stop (drv_stop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic quiet(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            quiet("idle");
        end
    endtask

    task automatic pulse_byte();
        drv_byte = 1'b1;
        step();
        drv_byte = 1'b0;
        quiet("byte");
    endtask

    task automatic stop_and_expect(input string tag, input logic [1:0] exp_done, input logic [1:0] exp_err);
        drv_stop = 1'b1;
        step();
        drv_stop = 1'b0;
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(drv_start), 32'd0);
        check({tag, "_addr"}, 32'(drv_addr), 32'd0);
        check({tag, "_rw"}, 32'(drv_rw), 32'd0);
    endtask

    task automatic rand_port(input int p);
        if (p == 1) begin
            req_addr1 = AW'($urandom);
            req_rw1   = 1'($urandom);
            req_len1  = LW'($urandom_range(0, 15));
        end else begin
            req_addr0 = AW'($urandom);
            req_rw0   = 1'($urandom);
            req_len0  = LW'($urandom_range(0, 15));
        end
    endtask

    // kind: 0 normal, 1 normal with STOP on the last byte, 2 NACK after k bytes,
    // 3 STOP after k < len bytes, 4 silence after k bytes until the watchdog fires.
    task automatic run_txn(input int kind, input int kin, input logic [1:0] add_req);
        int            owner;
        int            k;
        int            waited;
        int            n;
        logic [1:0]    oh;
        logic [LW-1:0] len;
        logic [AW-1:0] a;
        logic          rw;

        owner = (req == 2'b11) ? ((last_owner == 0) ? 1 : 0) : (req[1] ? 1 : 0);
        oh    = (owner == 1) ? 2'b10 : 2'b01;
        len   = (owner == 1) ? req_len1 : req_len0;
        a     = (owner == 1) ? req_addr1 : req_addr0;
        rw    = (owner == 1) ? req_rw1 : req_rw0;
        n     = int'(len);
        if (kin >= 0) k = kin;
        else if (n == 0) k = 0;
        else if (kind == 4) k = $urandom_range(0, n);
        else k = $urandom_range(0, n - 1);

        waited = 0;
        do begin
            step();
            waited++;
        end while (grant == 2'b00 && waited < 64);
        check("grant", 32'(grant), 32'(oh));
        check("grant_latency", 32'(waited), 32'd1);
        check("busy_at_grant", 32'(busy), 32'd1);

        step();
        if (n == 0) begin
            check("zero_len_err", 32'(err), 32'(oh));
            check("zero_len_done", 32'(done), 32'd0);
            check("zero_len_no_start", 32'(drv_start), 32'd0);
        end else begin
            check("drv_start", 32'(drv_start), 32'd1);
            check("drv_addr", 32'(drv_addr), 32'(a));
            check("drv_rw", 32'(drv_rw), 32'(rw));
            quiet("start");
            case (kind)
                0, 1: begin
                    for (int i = 0; i < n; i++) begin
                        idle_cycles($urandom_range(0, 3));
                        if (kind == 1 && i == n - 1) begin
                            drv_byte = 1'b1;
                            drv_stop = 1'b1;
                            step();
                            drv_byte = 1'b0;
                            drv_stop = 1'b0;
                        end else begin
                            pulse_byte();
                        end
                    end
                    if (kind == 0) begin
                        idle_cycles($urandom_range(0, 3));
                        drv_stop = 1'b1;
                        step();
                        drv_stop = 1'b0;
                    end
                    check("ok_done", 32'(done), 32'(oh));
                    check("ok_err", 32'(err), 32'd0);
                end
                2: begin
                    for (int i = 0; i < k; i++) begin
                        idle_cycles($urandom_range(0, 3));
                        pulse_byte();
                    end
                    drv_nack = 1'b1;
                    step();
                    drv_nack = 1'b0;
                    quiet("nack_pulse");
                    idle_cycles($urandom_range(0, 3));
                    stop_and_expect("nack", 2'b00, oh);
                end
                3: begin
                    for (int i = 0; i < k; i++) begin
                        idle_cycles($urandom_range(0, 3));
                        pulse_byte();
                    end
                    idle_cycles($urandom_range(0, 3));
                    stop_and_expect("short", 2'b00, oh);
                end
                default: begin
                    for (int i = 0; i < k; i++) begin
                        idle_cycles($urandom_range(0, 3));
                        pulse_byte();
                    end
                    for (int i = 1; i <= TO; i++) begin
                        step();
                        if (i < TO) check("timeout_early", 32'(err), 32'd0);
                        else check("timeout_err", 32'(err), 32'(oh));
                        check("timeout_done", 32'(done), 32'd0);
                    end
                end
            endcase
        end

        check("addr_hold", 32'(drv_addr), 32'(a));
        check("busy_at_outcome", 32'(busy), 32'd1);
        req = (req & ~oh) | add_req;
        last_owner = owner;
        for (int i = 1; i <= GP; i++) begin
            step();
            quiet("gap");
            check("gap_grant", 32'(grant), 32'd0);
            check("gap_start", 32'(drv_start), 32'd0);
            check("gap_busy", 32'(busy), (i < GP) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic [1:0] add;
        int         guard;

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        // Round-robin with both requesters held
        req_addr0 = 7'h11; req_rw0 = 1'b0; req_len0 = 4'd1;
        req_addr1 = 7'h22; req_rw1 = 1'b1; req_len1 = 4'd1;
        req = 2'b11;
        run_txn(0, 0, 2'b11);
        run_txn(0, 0, 2'b11);
        run_txn(0, 0, 2'b11);
        run_txn(0, 0, 2'b00);
        run_txn(0, 0, 2'b00);

        // Single write
        req_addr0 = 7'h47; req_rw0 = 1'b0; req_len0 = 4'd2;
        req = 2'b01;
        run_txn(0, 0, 2'b00);

        // NACK after the first byte
        req_addr1 = 7'h5a; req_rw1 = 1'b1; req_len1 = 4'd3;
        req = 2'b10;
        run_txn(2, 1, 2'b00);

        // Short transfer
        req_addr0 = 7'h33; req_rw0 = 1'b1; req_len0 = 4'd4;
        req = 2'b01;
        run_txn(3, 2, 2'b00);

        // Timeout with no driver activity
        req_addr1 = 7'h09; req_rw1 = 1'b0; req_len1 = 4'd5;
        req = 2'b10;
        run_txn(4, 0, 2'b00);

        // Maximum length with STOP on the final byte
        req_addr1 = 7'h7f; req_rw1 = 1'b1; req_len1 = 4'd15;
        req = 2'b10;
        run_txn(1, 0, 2'b00);

        // Zero length
        req_addr0 = 7'h12; req_rw0 = 1'b1; req_len0 = 4'd0;
        req = 2'b01;
        run_txn(0, 0, 2'b00);

        // Randomized mix
        rand_port(0);
        rand_port(1);
        req = 2'($urandom_range(1, 3));
        for (int it = 0; it < 12; it++) begin
            add = (it == 11) ? 2'b00 : 2'($urandom_range(0, 3));
            run_txn($urandom_range(0, 4), -1, add);
            rand_port(last_owner);
            if (req == 2'b00 && it < 11) req = 2'($urandom_range(1, 3));
        end
        guard = 0;
        while (req != 2'b00 && guard < 4) begin
            run_txn(0, -1, 2'b00);
            guard++;
        end

        // Reset in the middle of XFER
        req_addr0 = 7'h6c; req_rw0 = 1'b1; req_len0 = 4'd3;
        req = 2'b01;
        step();
        check("rst_test_grant", 32'(grant), 32'd1);
        step();
        check("rst_test_start", 32'(drv_start), 32'd1);
        pulse_byte();
        rst = 1'b1;
        req = 2'b00;
        step();
        check_all_zero("rst_mid");
        rst = 1'b0;
        last_owner = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            quiet("post_rst");
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_grant", 32'(grant), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_scheduler.md
# i2c_master_scheduler

Arbiter and transaction sequencer in front of the single `pu_i2c_master_driver` of the I2C master PU. It accepts transaction requests from two requesters: port 0 is the NITTA cycle path, port 1 is the configuration/polling path. It grants the requesters round-robin and drives the driver's start, address and rw inputs. It counts transferred bytes and reports per-requester completion or error.

## Interface
Parameters:
- ADDR_WIDTH, 7, I2C device address width
- LEN_WIDTH, 4, byte-count width; request length range 1..2^LEN_WIDTH-1
- TIMEOUT, 1024, max clk cycles without byte or stop activity before abort
- GAP, 4, idle clk cycles enforced between consecutive transactions

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  2  request level per requester; held until done/err
- req_addr0, req_addr1  in  ADDR_WIDTH  target address per requester
- req_rw0, req_rw1  in  1  0 = write, 1 = read
- req_len0, req_len1  in  LEN_WIDTH  bytes to transfer
- grant  out  2  one-hot 1-cycle pulse when a request is accepted
- done  out  2  1-cycle pulse: transaction completed, all bytes transferred
- err  out  2  1-cycle pulse: zero length, timeout, short transfer or NACK
- busy  out  1  high from grant until return to IDLE
- drv_start  out  1  1-cycle start_transaction pulse to the driver
- drv_addr  out  ADDR_WIDTH  latched address to the driver
- drv_rw  out  1  latched rw to the driver
- drv_byte  in  1  1-cycle pulse per byte moved (driver i2c_prepare on write, ready_write on read)
- drv_nack  in  1  1-cycle pulse: slave NACK seen
- drv_stop  in  1  1-cycle pulse: STOP condition observed on the bus (flag_stop)

## Operation
- States: IDLE, START, XFER, WAIT_STOP, GAP_WAIT.
- IDLE: if any req bit is set, pick the owner round-robin. `last` holds the most recent owner, reset 1, so requester 0 wins first when both are pending.
  - Latch addr, rw and len of the owner. Pulse grant[owner]. Go to START.
  - If the latched len = 0: pulse err[owner] instead and go to GAP_WAIT. No drv_start is issued.
- START: pulse drv_start for one cycle, clear the byte counter, go to XFER.
- XFER: each drv_byte increments the counter (LEN_WIDTH bits). When counter+1 = len on a drv_byte, go to WAIT_STOP.
  - drv_nack: go to WAIT_STOP with the error flag set.
  - drv_stop before the full count: pulse err[owner] and go to GAP_WAIT.
- WAIT_STOP: on drv_stop, pulse done[owner] if the error flag is clear, else pulse err[owner]. Go to GAP_WAIT.
  - Extra drv_byte pulses in this state are ignored; the counter saturates.
- GAP_WAIT: count GAP cycles, update last = owner, go to IDLE. A new grant is issued in the first IDLE cycle.
- Timeout: in START, XFER or WAIT_STOP, a watchdog counts cycles since the last drv_byte/drv_stop/state entry. When it reaches TIMEOUT, pulse err[owner] and go to GAP_WAIT. The driver is not reset by this block.
- Simultaneous events in the same cycle:
  - drv_byte completing the count together with drv_stop: done.
  - drv_nack together with drv_stop: err.
  - Timeout together with drv_stop: the drv_stop outcome takes precedence.
- If req drops mid-transaction, the transaction still completes and reports normally.
- drv_addr and drv_rw stay stable from grant until the next grant.

## Timing
- Reset values:
  - State: IDLE.
  - grant, done, err, drv_start, busy: 0.
  - drv_addr: 0. drv_rw: 0. last: 1. All counters: 0.
- rst mid-transaction returns to IDLE next cycle with no done/err pulse.
- Sequencing with req high in IDLE at cycle T:
  - grant and busy at T+1. drv_start at T+2.
  - Earliest done: 1 cycle after the drv_stop pulse.
- busy falls on entry to IDLE. The next grant comes at the earliest GAP+1 cycles after done/err.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single write: req[0]=1, addr0=0x47, rw0=0, len0=2. Send 2 drv_byte, then drv_stop → grant=01, drv_start one cycle later with drv_addr=0x47 and drv_rw=0, done=01, err=00.
- Round-robin: req=11 held, each transaction len=1 and completed. Grant order 01, 10, 01, 10. Consecutive grants at least GAP+1 cycles apart.
- NACK: req[1], len=3. drv_nack after the 1st byte, then drv_stop → err=10, no done.
- Short transfer: len=4, only 2 drv_byte, then drv_stop → err pulse, return to IDLE.
- Timeout: TIMEOUT=16, grant issued, no driver activity → err exactly 16 cycles after the last state entry; busy low after GAP.
- Zero length and reset: len0=0 → err=01, no drv_start. Separately, assert rst during XFER → all outputs 0 next cycle, no done/err.
